// File: rtl/lane_sup_pkg.sv
// ---------------------------------------------------------------------------
// lane_sup_pkg
// Shared definitions for the lane lock supervisor: FSM state encoding and the
// default widths/lane count used by the supervisor, its interface and the
// counters it instantiates.
// ---------------------------------------------------------------------------
package lane_sup_pkg;

    localparam int N_LANES_DEF        = 20;
    localparam int NB_TIMER_DEF       = 16;
    localparam int NB_QUAL_DEF        = 8;
    localparam int NB_RESTART_CNT_DEF = 8;

    // The numeric codes are visible on o_state, so they are fixed explicitly.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_QUALIFY   = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_RESTART   = 3'd4
    } sup_state_e;

endpackage

// File: rtl/lane_lock_supervisor_if.sv
// ---------------------------------------------------------------------------
// lane_lock_supervisor_if
// Bundles the control, lane-status, register-file and status signals of the
// lane lock supervisor.
//   master : side that drives enable/valid/signal_ok/block_lock and the
//            register-file controls, and observes the status outputs
//   slave  : the supervisor itself
// Signal names keep the i_/o_ direction prefixes as seen from the supervisor.
// ---------------------------------------------------------------------------
interface lane_lock_supervisor_if
    import lane_sup_pkg::*;
#(
    parameter int N_LANES        = N_LANES_DEF,
    parameter int NB_TIMER       = NB_TIMER_DEF,
    parameter int NB_QUAL        = NB_QUAL_DEF,
    parameter int NB_RESTART_CNT = NB_RESTART_CNT_DEF
);

    logic                      i_enable;
    logic                      i_valid;
    logic                      i_signal_ok;
    logic [N_LANES-1:0]        i_block_lock;
    logic [N_LANES-1:0]        i_rf_lane_mask;
    logic [NB_TIMER-1:0]       i_rf_lock_timeout;
    logic [NB_QUAL-1:0]        i_rf_qualify_cycles;
    logic [NB_QUAL-1:0]        i_rf_restart_cycles;
    logic                      i_rf_clear_status;

    logic [N_LANES-1:0]        o_lane_signal_ok;
    logic                      o_all_locked;
    logic                      o_align_enable;
    logic [2:0]                o_state;
    logic [N_LANES-1:0]        o_lost_lock_sticky;
    logic [NB_RESTART_CNT-1:0] o_restart_count;

    modport master (
        output i_enable, i_valid, i_signal_ok, i_block_lock, i_rf_lane_mask,
               i_rf_lock_timeout, i_rf_qualify_cycles, i_rf_restart_cycles,
               i_rf_clear_status,
        input  o_lane_signal_ok, o_all_locked, o_align_enable, o_state,
               o_lost_lock_sticky, o_restart_count
    );

    modport slave (
        input  i_enable, i_valid, i_signal_ok, i_block_lock, i_rf_lane_mask,
               i_rf_lock_timeout, i_rf_qualify_cycles, i_rf_restart_cycles,
               i_rf_clear_status,
        output o_lane_signal_ok, o_all_locked, o_align_enable, o_state,
               o_lost_lock_sticky, o_restart_count
    );

endinterface

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear and a terminal-count flag.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   clear_i      : return the count to zero (wins over inc_i)
//   inc_i        : advance by one; the count holds at all-ones
//   limit_i      : terminal value
//   done_o       : count has reached or passed limit_i
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             done_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;

    // Count register: clear has priority, increments stop at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + ONE;
        end
    end

    // ">=" rather than "==" so that lowering the limit mid-count still
    // terminates instead of waiting for a wrap that never comes.
    assign done_o = (count_q >= limit_i);

endmodule

// File: rtl/lane_lock_supervisor.sv
// ---------------------------------------------------------------------------
// lane_lock_supervisor
// Sequences the per-lane block synchronisers of the receive PCS: gates each
// lane's signal_ok, restarts lanes that miss the lock timeout, qualifies a
// stable all-lane lock before enabling alignment, and keeps sticky lost-lock
// status plus a saturating restart counter.
// Ports:
//   i_clock, i_reset : clock, asynchronous active-high reset
//   bus (slave)      : enable/valid/signal_ok, per-lane block_lock,
//                      register-file controls in; lane signal_ok, lock
//                      status, state code, sticky bits, restart count out
// All outputs are registered from the next-state values.
// ---------------------------------------------------------------------------
module lane_lock_supervisor
    import lane_sup_pkg::*;
#(
    parameter int N_LANES        = N_LANES_DEF,
    parameter int NB_TIMER       = NB_TIMER_DEF,
    parameter int NB_QUAL        = NB_QUAL_DEF,
    parameter int NB_RESTART_CNT = NB_RESTART_CNT_DEF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    lane_lock_supervisor_if.slave bus
);

    localparam logic [NB_TIMER-1:0]       TIMER_ONE = NB_TIMER'(1);
    localparam logic [NB_QUAL-1:0]        QUAL_ONE  = NB_QUAL'(1);
    localparam logic [NB_RESTART_CNT-1:0] CNT_ONE   = NB_RESTART_CNT'(1);

    sup_state_e                state_q, state_d;
    logic [N_LANES-1:0]        restartLanes_q, restartLanes_d;
    logic [N_LANES-1:0]        laneOk_q, laneOk_d;
    logic                      locked_q, locked_d;
    logic [N_LANES-1:0]        sticky_q, sticky_d;
    logic [NB_RESTART_CNT-1:0] restartCount_q, restartCount_d;

    logic               abort;
    logic               allLk;
    logic [N_LANES-1:0] droppedLanes;
    logic [N_LANES-1:0] stickySet;
    logic               restartEntry;

    logic                timerClr, timerInc, timerDone, timeoutHit;
    logic [NB_TIMER-1:0] timerLimit;
    logic                qualClr, qualInc, qualDone;
    logic                rstClr, rstInc, rstDone;
    logic [NB_QUAL-1:0]  rstLimit;

    assign abort        = !bus.i_enable || !bus.i_signal_ok;
    assign allLk        = &(bus.i_block_lock | bus.i_rf_lane_mask);
    assign droppedLanes = ~bus.i_block_lock & ~bus.i_rf_lane_mask;

    // The counters compare "count >= limit"; the limits are shifted by one
    // so that the timer fires on timer+1 == timeout and restart ends on
    // rst+1 >= max(restart_cycles, 1).
    assign timerLimit = bus.i_rf_lock_timeout - TIMER_ONE;
    assign rstLimit   = (bus.i_rf_restart_cycles == '0) ? '0
                                                        : (bus.i_rf_restart_cycles - QUAL_ONE);
    assign timeoutHit = (bus.i_rf_lock_timeout != '0) && timerDone;

    // Counter controls. The timer survives QUALIFY->WAIT_LOCK so that the
    // timeout bounds the whole acquisition, but restarts after LOCKED or
    // RESTART. It only advances on cycles that stay in WAIT_LOCK.
    always_comb begin
        timerClr = abort || (state_q == ST_IDLE) || (state_q == ST_LOCKED)
                   || (state_q == ST_RESTART);
        timerInc = (state_q == ST_WAIT_LOCK) && bus.i_valid && !allLk && !timeoutHit;
        qualClr  = abort || (state_q != ST_QUALIFY);
        qualInc  = (state_q == ST_QUALIFY) && bus.i_valid && allLk && !qualDone;
        rstClr   = abort || (state_q != ST_RESTART);
        rstInc   = (state_q == ST_RESTART) && bus.i_valid && !rstDone;
    end

    sat_counter #(.WIDTH(NB_TIMER)) u_timer (
        .clock   (i_clock),
        .reset   (i_reset),
        .clear_i (timerClr),
        .inc_i   (timerInc),
        .limit_i (timerLimit),
        .done_o  (timerDone)
    );

    sat_counter #(.WIDTH(NB_QUAL)) u_qual (
        .clock   (i_clock),
        .reset   (i_reset),
        .clear_i (qualClr),
        .inc_i   (qualInc),
        .limit_i (bus.i_rf_qualify_cycles),
        .done_o  (qualDone)
    );

    sat_counter #(.WIDTH(NB_QUAL)) u_rst (
        .clock   (i_clock),
        .reset   (i_reset),
        .clear_i (rstClr),
        .inc_i   (rstInc),
        .limit_i (rstLimit),
        .done_o  (rstDone)
    );

    // State and registered outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q        <= ST_IDLE;
            restartLanes_q <= '0;
            laneOk_q       <= '0;
            locked_q       <= 1'b0;
            sticky_q       <= '0;
            restartCount_q <= '0;
        end else begin
            state_q        <= state_d;
            restartLanes_q <= restartLanes_d;
            laneOk_q       <= laneOk_d;
            locked_q       <= locked_d;
            sticky_q       <= sticky_d;
            restartCount_q <= restartCount_d;
        end
    end

    // Next state. Abort overrides everything, independent of i_valid; every
    // other transition is evaluated only on valid cycles except leaving IDLE.
    always_comb begin
        state_d        = state_q;
        restartLanes_d = restartLanes_q;
        stickySet      = '0;
        restartEntry   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (bus.i_valid) begin
                        if (allLk) begin
                            state_d = ST_QUALIFY;
                        end else if (timeoutHit) begin
                            state_d        = ST_RESTART;
                            restartLanes_d = droppedLanes;
                            restartEntry   = 1'b1;
                        end
                    end
                end
                ST_QUALIFY: begin
                    if (bus.i_valid) begin
                        if (!allLk) begin
                            state_d = ST_WAIT_LOCK;
                        end else if (qualDone) begin
                            state_d = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (bus.i_valid && !allLk) begin
                        state_d   = ST_WAIT_LOCK;
                        stickySet = droppedLanes;
                    end
                end
                ST_RESTART: begin
                    if (bus.i_valid && rstDone) begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output values for the coming cycle. Clear-status loses to a same-cycle
    // set/increment so no lost-lock or restart event goes unrecorded.
    always_comb begin
        laneOk_d = '0;
        locked_d = 1'b0;
        case (state_d)
            ST_WAIT_LOCK, ST_QUALIFY: laneOk_d = ~bus.i_rf_lane_mask;
            ST_LOCKED: begin
                laneOk_d = ~bus.i_rf_lane_mask;
                locked_d = 1'b1;
            end
            ST_RESTART: laneOk_d = ~bus.i_rf_lane_mask & ~restartLanes_d;
            default:    laneOk_d = '0;
        endcase

        sticky_d = (bus.i_rf_clear_status ? '0 : sticky_q) | stickySet;

        if (restartEntry) begin
            restartCount_d = (restartCount_q == '1) ? restartCount_q
                                                    : (restartCount_q + CNT_ONE);
        end else if (bus.i_rf_clear_status) begin
            restartCount_d = '0;
        end else begin
            restartCount_d = restartCount_q;
        end
    end

    assign bus.o_lane_signal_ok   = laneOk_q;
    assign bus.o_all_locked       = locked_q;
    assign bus.o_align_enable     = locked_q;
    assign bus.o_state            = state_q;
    assign bus.o_lost_lock_sticky = sticky_q;
    assign bus.o_restart_count    = restartCount_q;

endmodule

// File: tb/tb_lane_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_lane_lock_supervisor
// Directed bench for lane_lock_supervisor with a cycle-level reference model
// of the lock-acquisition rules and hand-computed checkpoints.
// ---------------------------------------------------------------------------
module tb_lane_lock_supervisor;

    localparam int NL = 20;
    localparam logic [NL-1:0] ALL = '1;

    localparam int M_IDLE    = 0;
    localparam int M_WAIT    = 1;
    localparam int M_QUALIFY = 2;
    localparam int M_LOCKED  = 3;
    localparam int M_RESTART = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   testsRun    = 0;
    int   testsFailed = 0;

    lane_lock_supervisor_if busIf ();

    lane_lock_supervisor dut (
        .i_clock (clock),
        .i_reset (reset),
        .bus     (busIf)
    );

    always #5 clock = ~clock;

    // Reference model state: the abstract progress through acquisition plus
    // the values the outputs must show after each clock.
    typedef struct packed {
        int          st;
        int          timer;
        int          qual;
        int          rstc;
        logic [NL-1:0] restartLanes;
        logic [NL-1:0] sticky;
        int          rcount;
        logic [NL-1:0] laneOk;
        logic        locked;
    } ModelT;

    ModelT m;

    function automatic ModelT modelNext(input ModelT c, input logic en, input logic sok,
                                        input logic valid, input logic [NL-1:0] lock,
                                        input logic [NL-1:0] mask, input int timeout,
                                        input int qc, input int rc, input logic clr);
        ModelT         n;
        logic          allLk;
        logic [NL-1:0] dropped;
        logic [NL-1:0] stickySet;
        bit            countUp;
        int            restartLen;
        n          = c;
        allLk      = ((lock | mask) == ALL);
        dropped    = ~lock & ~mask;
        stickySet  = '0;
        countUp    = 1'b0;
        restartLen = (rc > 1) ? rc : 1;
        if (!en || !sok) begin
            n.st    = M_IDLE;
            n.timer = 0;
            n.qual  = 0;
            n.rstc  = 0;
        end else if (c.st == M_IDLE) begin
            n.st    = M_WAIT;
            n.timer = 0;
        end else if (valid) begin
            if (c.st == M_WAIT) begin
                if (allLk) begin
                    n.st   = M_QUALIFY;
                    n.qual = 0;
                end else if (timeout != 0 && c.timer + 1 >= timeout) begin
                    n.st           = M_RESTART;
                    n.restartLanes = dropped;
                    n.rstc         = 0;
                    countUp        = 1'b1;
                end else begin
                    n.timer = (c.timer < 65535) ? c.timer + 1 : 65535;
                end
            end else if (c.st == M_QUALIFY) begin
                if (!allLk) n.st = M_WAIT;
                else if (c.qual >= qc) n.st = M_LOCKED;
                else n.qual = c.qual + 1;
            end else if (c.st == M_LOCKED) begin
                if (!allLk) begin
                    stickySet = dropped;
                    n.st      = M_WAIT;
                    n.timer   = 0;
                end
            end else if (c.st == M_RESTART) begin
                if (c.rstc + 1 >= restartLen) begin
                    n.st    = M_WAIT;
                    n.timer = 0;
                end else begin
                    n.rstc = c.rstc + 1;
                end
            end
        end
        n.sticky = (clr ? '0 : c.sticky) | stickySet;
        if (countUp) n.rcount = (c.rcount < 255) ? c.rcount + 1 : 255;
        else if (clr) n.rcount = 0;
        if (n.st == M_IDLE) n.laneOk = '0;
        else if (n.st == M_RESTART) n.laneOk = ~mask & ~n.restartLanes;
        else n.laneOk = ~mask;
        n.locked = (n.st == M_LOCKED);
        return n;
    endfunction

    // Advance the model alongside the DUT.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m <= '0;
        end else begin
            m <= modelNext(m, busIf.i_enable, busIf.i_signal_ok, busIf.i_valid,
                           busIf.i_block_lock, busIf.i_rf_lane_mask,
                           int'(busIf.i_rf_lock_timeout), int'(busIf.i_rf_qualify_cycles),
                           int'(busIf.i_rf_restart_cycles), busIf.i_rf_clear_status);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output against the model on the falling edge.
    always @(negedge clock) begin
        if (!reset) begin
            checkOutput("cmp.state",        32'(busIf.o_state),            32'(m.st));
            checkOutput("cmp.laneOk",       32'(busIf.o_lane_signal_ok),   32'(m.laneOk));
            checkOutput("cmp.allLocked",    32'(busIf.o_all_locked),       32'(m.locked));
            checkOutput("cmp.alignEnable",  32'(busIf.o_align_enable),     32'(m.locked));
            checkOutput("cmp.sticky",       32'(busIf.o_lost_lock_sticky), 32'(m.sticky));
            checkOutput("cmp.restartCount", 32'(busIf.o_restart_count),    32'(m.rcount));
        end
    end

    task automatic applyStimulus(input logic en, input logic sok, input logic valid,
                                 input logic [NL-1:0] lock, input logic [NL-1:0] mask,
                                 input logic [15:0] timeout, input logic [7:0] qc,
                                 input logic [7:0] rc, input logic clr);
        busIf.i_enable            = en;
        busIf.i_signal_ok         = sok;
        busIf.i_valid             = valid;
        busIf.i_block_lock        = lock;
        busIf.i_rf_lane_mask      = mask;
        busIf.i_rf_lock_timeout   = timeout;
        busIf.i_rf_qualify_cycles = qc;
        busIf.i_rf_restart_cycles = rc;
        busIf.i_rf_clear_status   = clr;
    endtask

    // Inputs change 1 time unit after a rising edge; checkpoints are read there too.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".state"},        32'(busIf.o_state),            32'h0);
        checkOutput({tag, ".laneOk"},       32'(busIf.o_lane_signal_ok),   32'h0);
        checkOutput({tag, ".allLocked"},    32'(busIf.o_all_locked),       32'h0);
        checkOutput({tag, ".alignEnable"},  32'(busIf.o_align_enable),     32'h0);
        checkOutput({tag, ".sticky"},       32'(busIf.o_lost_lock_sticky), 32'h0);
        checkOutput({tag, ".restartCount"}, 32'(busIf.o_restart_count),    32'h0);
    endtask

    initial begin
        applyStimulus(0, 0, 0, '0, '0, 16'd0, 8'd0, 8'd0, 0);
        #1 reset = 1'b1;
        #3;
        checkAllZero("reset");
        #8 reset = 1'b0;

        // Acquisition with qualify_cycles = 3.
        applyStimulus(1, 1, 1, '0, '0, 16'd0, 8'd3, 8'd10, 0);
        step(1);
        checkOutput("t1.wait.state", 32'(busIf.o_state), 32'd1);
        checkOutput("t1.wait.laneOk", 32'(busIf.o_lane_signal_ok), 32'hFFFFF);
        checkOutput("t1.model.wait", 32'(m.st), 32'd1);
        busIf.i_block_lock = ALL;
        step(1);
        checkOutput("t1.qualify.state", 32'(busIf.o_state), 32'd2);
        step(3);
        checkOutput("t1.qualify3.state", 32'(busIf.o_state), 32'd2);
        checkOutput("t1.qualify3.allLocked", 32'(busIf.o_all_locked), 32'd0);
        step(1);
        checkOutput("t1.locked.state", 32'(busIf.o_state), 32'd3);
        checkOutput("t1.locked.allLocked", 32'(busIf.o_all_locked), 32'd1);
        checkOutput("t1.locked.align", 32'(busIf.o_align_enable), 32'd1);
        checkOutput("t1.locked.laneOk", 32'(busIf.o_lane_signal_ok), 32'hFFFFF);

        // Drop lane 12 while locked.
        busIf.i_block_lock = ALL & ~(NL'(1) << 12);
        step(1);
        checkOutput("t3.drop.sticky", 32'(busIf.o_lost_lock_sticky), 32'h01000);
        checkOutput("t3.drop.align", 32'(busIf.o_align_enable), 32'd0);
        checkOutput("t3.drop.state", 32'(busIf.o_state), 32'd1);
        busIf.i_block_lock = ALL;
        step(1);
        checkOutput("t5.qualify.state", 32'(busIf.o_state), 32'd2);

        // Stalled valid freezes qualification progress.
        busIf.i_valid = 1'b0;
        step(50);
        checkOutput("t5.frozen.state", 32'(busIf.o_state), 32'd2);
        busIf.i_valid = 1'b1;
        step(3);
        checkOutput("t5.resume3.state", 32'(busIf.o_state), 32'd2);
        step(1);
        checkOutput("t5.resume4.state", 32'(busIf.o_state), 32'd3);

        // Clear-status coinciding with a new drop keeps the new event.
        busIf.i_rf_clear_status = 1'b1;
        busIf.i_block_lock      = ALL & ~(NL'(1) << 12);
        step(1);
        checkOutput("t3.clrDrop.sticky", 32'(busIf.o_lost_lock_sticky), 32'h01000);
        checkOutput("t3.model.sticky", 32'(m.sticky), 32'h01000);
        busIf.i_block_lock = ALL;
        step(1);
        checkOutput("t3.clrOnly.sticky", 32'(busIf.o_lost_lock_sticky), 32'h0);
        checkOutput("t3.clrOnly.state", 32'(busIf.o_state), 32'd2);
        busIf.i_rf_clear_status = 1'b0;

        // Signal-ok loss aborts to IDLE even without valid.
        busIf.i_signal_ok = 1'b0;
        busIf.i_valid     = 1'b0;
        step(1);
        checkOutput("t5.abort.state", 32'(busIf.o_state), 32'd0);
        checkOutput("t5.abort.laneOk", 32'(busIf.o_lane_signal_ok), 32'h0);
        busIf.i_signal_ok = 1'b1;
        busIf.i_valid     = 1'b1;
        step(1);
        checkOutput("t5.rearm.state", 32'(busIf.o_state), 32'd1);

        // Masked lane 0 never locks but is ignored.
        busIf.i_rf_lane_mask = NL'(1);
        busIf.i_block_lock   = ALL & ~NL'(1);
        step(1);
        checkOutput("t4.qualify.state", 32'(busIf.o_state), 32'd2);
        checkOutput("t4.qualify.laneOk", 32'(busIf.o_lane_signal_ok), 32'hFFFFE);
        step(4);
        checkOutput("t4.locked.state", 32'(busIf.o_state), 32'd3);
        checkOutput("t4.locked.laneOk", 32'(busIf.o_lane_signal_ok), 32'hFFFFE);

        // Lanes 0 and 7 never lock: timeout 100, restart for 10 cycles.
        busIf.i_rf_lane_mask      = '0;
        busIf.i_block_lock        = 20'hFFF7E;
        busIf.i_rf_lock_timeout   = 16'd100;
        busIf.i_rf_restart_cycles = 8'd10;
        step(1);
        checkOutput("t2.wait.state", 32'(busIf.o_state), 32'd1);
        checkOutput("t2.wait.sticky", 32'(busIf.o_lost_lock_sticky), 32'h00081);
        step(99);
        checkOutput("t2.preTimeout.state", 32'(busIf.o_state), 32'd1);
        step(1);
        checkOutput("t2.restart.state", 32'(busIf.o_state), 32'd4);
        checkOutput("t2.restart.laneOk", 32'(busIf.o_lane_signal_ok), 32'hFFF7E);
        checkOutput("t2.restart.count", 32'(busIf.o_restart_count), 32'd1);
        checkOutput("t2.model.restart", 32'(m.st), 32'd4);
        step(9);
        checkOutput("t2.restart9.state", 32'(busIf.o_state), 32'd4);
        step(1);
        checkOutput("t2.rewait.state", 32'(busIf.o_state), 32'd1);
        checkOutput("t2.rewait.laneOk", 32'(busIf.o_lane_signal_ok), 32'hFFFFF);
        step(99);
        checkOutput("t2.rewait99.state", 32'(busIf.o_state), 32'd1);
        step(1);
        checkOutput("t2.restart2.state", 32'(busIf.o_state), 32'd4);
        checkOutput("t2.restart2.count", 32'(busIf.o_restart_count), 32'd2);

        // Back-to-back timeouts: one restart every two cycles, count saturates.
        busIf.i_rf_lock_timeout   = 16'd1;
        busIf.i_rf_restart_cycles = 8'd1;
        step(600);
        checkOutput("t6.sat.count", 32'(busIf.o_restart_count), 32'd255);
        checkOutput("t6.sat.state", 32'(busIf.o_state), 32'd4);

        // Asynchronous reset in the middle of RESTART.
        #2 reset = 1'b1;
        #1;
        checkAllZero("t6.asyncReset");
        #3 reset = 1'b0;
        step(1);
        checkOutput("t6.afterReset.state", 32'(busIf.o_state), 32'd1);
        checkOutput("t6.afterReset.count", 32'(busIf.o_restart_count), 32'd0);
        step(2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/lane_lock_supervisor.md
Name: lane_lock_supervisor

Overview:
Controller that sequences the per-lane block synchronisers of the 20-lane receive PCS.
- Monitors the per-lane block_lock bus and gates each lane's signal_ok input.
- Forces a selective restart of lanes that fail to lock within a programmable timeout.
- Qualifies stable all-lane lock before enabling the downstream alignment-marker/deskew stage.
- Keeps sticky lost-lock status and a restart counter for the register file.

Parameters:
N_LANES, 20, number of PCS lanes supervised
NB_TIMER, 16, width of lock-timeout timer and limit
NB_QUAL, 8, width of qualify/restart counters and limits
NB_RESTART_CNT, 8, width of saturating restart counter

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous active-high reset
i_enable  in  1  supervisor enable; low forces IDLE
i_valid  in  1  datapath valid; all counters advance and lock conditions are evaluated only when high
i_signal_ok  in  1  global PMA signal ok; low forces IDLE
i_block_lock  in  N_LANES  per-lane block lock from the block synchronisers
i_rf_lane_mask  in  N_LANES  1 = lane ignored (held in reset, excluded from all-locked)
i_rf_lock_timeout  in  NB_TIMER  valid cycles allowed in WAIT_LOCK; 0 disables timeout
i_rf_qualify_cycles  in  NB_QUAL  valid cycles of continuous all-lock required
i_rf_restart_cycles  in  NB_QUAL  valid cycles a restarted lane's signal_ok is held low; 0 treated as 1
i_rf_clear_status  in  1  pulse: clear sticky bits and restart count
o_lane_signal_ok  out  N_LANES  per-lane signal_ok to the block synchronisers
o_all_locked  out  1  all unmasked lanes qualified locked
o_align_enable  out  1  enable for downstream alignment stage
o_state  out  3  current FSM state code
o_lost_lock_sticky  out  N_LANES  lane dropped lock while in LOCKED
o_restart_count  out  NB_RESTART_CNT  saturating count of RESTART entries

Behaviour:
- All outputs are registered. Inputs affect outputs one cycle later.
- Reset value of every output is 0; state is IDLE.
- Lock condition: all_lk = &(i_block_lock | i_rf_lane_mask). Drop condition: any unmasked lane with i_block_lock low.
- Masked lanes always see o_lane_signal_ok = 0.
- States: IDLE=0, WAIT_LOCK=1, QUALIFY=2, LOCKED=3, RESTART=4.
- Abort has highest priority. If i_enable or i_signal_ok is low in any state, next state is IDLE, all counters clear and o_lane_signal_ok = 0. This applies regardless of i_valid.
- IDLE: when i_enable && i_signal_ok, go to WAIT_LOCK; timer = 0.
- WAIT_LOCK:
  - o_lane_signal_ok = ~mask.
  - On i_valid: timer++.
  - If all_lk, go to QUALIFY; qual = 0. all_lk wins over timeout when both occur on the same cycle.
  - Else if timeout != 0 and timer+1 == timeout, go to RESTART; capture restart_lanes = ~i_block_lock & ~mask; rst = 0; restart_count is incremented, saturating at all-ones.
- QUALIFY:
  - On i_valid with a drop, go to WAIT_LOCK; timer keeps its value, so the timeout still bounds total acquisition time.
  - Else on i_valid: if qual == qualify_cycles, go to LOCKED; else qual++. With qualify_cycles = 0, the first valid cycle in QUALIFY passes.
- LOCKED:
  - o_all_locked = o_align_enable = 1.
  - On i_valid with a drop: OR the dropped lanes into sticky, go to WAIT_LOCK, timer = 0. No restart is issued directly from LOCKED.
- RESTART:
  - o_lane_signal_ok = ~mask & ~restart_lanes.
  - On i_valid: rst++. When rst+1 >= max(restart_cycles, 1), go to WAIT_LOCK; timer = 0.
- Mask change mid-operation takes effect immediately on the next evaluation. No state is flushed.
- i_rf_clear_status clears sticky bits and restart_count. If a set/increment occurs on the same cycle, the set/increment wins, so no event is lost.
- The timer saturates at all-ones (relevant only when timeout = 0).
- Reset mid-operation returns all outputs to 0 asynchronously.

Decomposition:
- Shared package lane_sup_pkg: state encodings (IDLE..RESTART, 3 bits) and the default N_LANES, NB_TIMER, NB_QUAL values.
- One natural sub-module, sat_counter: a parametric valid-gated counter with clear, terminal-count compare and saturation. It is instantiated for timer, qual and rst.
- The FSM and lane masking stay in the top module.

Test Plan:
1. Reset, then enable=1, signal_ok=1, all i_block_lock=1 at cycle 5, qualify=3, valid=1 → QUALIFY at cycle 6; o_all_locked and o_align_enable =1 four valid cycles later; o_lane_signal_ok=0xFFFFF.
2. timeout=100, lanes 0 and 7 never lock → RESTART after 100 valid cycles; o_lane_signal_ok=0xFFF7E for restart_cycles=10 cycles; restart_count=1; then WAIT_LOCK with timer=0.
3. From LOCKED, drop lane 12 for one valid cycle → o_lost_lock_sticky=0x01000, o_align_enable falls next cycle, state WAIT_LOCK. Assert i_rf_clear_status in the same cycle as a second drop of lane 12 → sticky stays 0x01000.
4. i_rf_lane_mask=0x00001, lane 0 lock=0, others 1 → reaches LOCKED; o_lane_signal_ok=0xFFFFE.
5. In QUALIFY with i_valid=0 for 50 cycles → state and counters frozen. Then drop i_signal_ok → IDLE next cycle, all o_lane_signal_ok=0.
6. Force 300 timeouts with NB_RESTART_CNT=8 → o_restart_count saturates at 255. Assert i_reset mid-RESTART → all outputs 0 immediately.
